// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the CPU request side.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_CNT_W  = 4;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM: write has priority, read data is registered.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately left unreset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: one outstanding request, LATENCY wait states.
// Optional DMEM_STATS_EN adds saturating handshake/stall counters.
//
// state | meaning
// IDLE  | ready for a request; stores commit on the accept edge
// WAIT  | modelling slow RAM, counting LATENCY cycles
// RESP  | response held until rsp_ready
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [15:0]       stat_errs,
  output logic [31:0]       stat_stall
`endif
);

  localparam logic [DMEM_CNT_W-1:0] LAT_LAST =
    (LATENCY > 0) ? DMEM_CNT_W'(LATENCY - 1) : '0;

  dmem_state_e           state, state_nxt;
  logic [DMEM_CNT_W-1:0] cnt, cnt_nxt;
  logic                  we_q, err_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  accept, req_oor;
  logic                  ram_we, ram_re;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_rdata;

  // Gated by rst_n so the CPU never sees ready while the block is held in reset.
  assign req_ready = rst_n & (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_oor   = |req_addr[31:ADDR_W];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          state_nxt = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAT_LAST) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q   <= req_we;
        err_q  <= req_oor;
        addr_q <= req_addr[ADDR_W-1:0];
      end
    end
  end

  // In IDLE the RAM sees the live request so zero-latency loads read on the accept edge.
  assign ram_addr = (state == IDLE) ? req_addr[ADDR_W-1:0] : addr_q;
  assign ram_we   = accept & req_we & ~req_oor;
  assign ram_re   = (state_nxt == RESP) & (state != RESP);

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? ram_rdata : '0;

`ifdef DMEM_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
      stat_stall  <= '0;
    end else begin
      if (rsp_hs && !we_q) stat_loads  <= sat_inc32(stat_loads);
      if (rsp_hs && we_q)  stat_stores <= sat_inc32(stat_stores);
      if (rsp_hs && err_q) stat_errs   <= sat_inc16(stat_errs);
      if (rsp_valid && !rsp_ready) stat_stall <= sat_inc32(stat_stall);
    end
  end
`endif

endmodule
